// File: rtl/i2c_target.sv
// Write-only I2C target receiver: START/STOP detection, 7-bit address match,
// open-drain ACK drive and per-byte hand-off with Accept back-pressure.
module i2c_target #(
    parameter logic [6:0] ADDRESS = 7'h3C
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic       Accept,
    output logic [7:0] Data,
    output logic       DataValid,
    output logic       Addressed
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned SHIFT_W = 7;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned SYNC_W  = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_DATA     = 3'd3,
        ST_DATA_ACK = 3'd4,
        ST_IGNORE   = 3'd5
    } state_e;

    logic [SYNC_W-1:0]  scl_sync_q;
    logic [SYNC_W-1:0]  sda_sync_q;
    logic               scl_dly_q;
    logic               sda_dly_q;

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [SHIFT_W-1:0] shift_q,     shift_d;
    logic               pend_q,      pend_d;
    logic [BYTE_W-1:0]  data_q,      data_d;
    logic               valid_q,     valid_d;
    logic               addressed_q, addressed_d;
    logic               sda_oe_q,    sda_oe_d;

    logic               scl_s;
    logic               sda_s;
    logic               scl_rise;
    logic               scl_fall;
    logic               sda_rise;
    logic               sda_fall;
    logic               start_det;
    logic               stop_det;
    logic [BYTE_W-1:0]  byte_c;
    logic               addr_match;

    // Open-drain pad: only ever pulls low or releases.
    assign SDA = sda_oe_q ? 1'b0 : 1'bz;

    // Two-flop synchronizers plus one delay stage; idle bus level is high.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], SCL};
            sda_sync_q <= {sda_sync_q[0], SDA};
            scl_dly_q  <= scl_sync_q[SYNC_W-1];
            sda_dly_q  <= sda_sync_q[SYNC_W-1];
        end
    end

    // Edge and bus-condition decode from synchronized vs delayed copies.
    always_comb begin
        scl_s      = scl_sync_q[SYNC_W-1];
        sda_s      = sda_sync_q[SYNC_W-1];
        scl_rise   = scl_s & ~scl_dly_q;
        scl_fall   = ~scl_s & scl_dly_q;
        sda_rise   = sda_s & ~sda_dly_q;
        sda_fall   = ~sda_s & sda_dly_q;
        start_det  = sda_fall & scl_s;
        stop_det   = sda_rise & scl_s;
        byte_c     = {shift_q, sda_s};
        addr_match = (byte_c[7:1] == ADDRESS) && !byte_c[0];
    end

    // FSM state and datapath registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            pend_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            addressed_q <= 1'b0;
            sda_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            pend_q      <= pend_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            addressed_q <= addressed_d;
            sda_oe_q    <= sda_oe_d;
        end
    end

    // Next-state and output decode; pend_q marks a byte awaiting its ACK slot.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        pend_d      = pend_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        addressed_d = addressed_q;
        sda_oe_d    = sda_oe_q;

        unique case (state_q)
            ST_IDLE: begin
                sda_oe_d = 1'b0;
                if (start_det) begin
                    state_d = ST_ADDR;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            end

            ST_ADDR, ST_DATA: begin
                if (start_det) begin
                    state_d     = ST_ADDR;
                    cnt_d       = '0;
                    pend_d      = 1'b0;
                    addressed_d = 1'b0;
                    sda_oe_d    = 1'b0;
                end else if (stop_det) begin
                    state_d     = ST_IDLE;
                    pend_d      = 1'b0;
                    addressed_d = 1'b0;
                    sda_oe_d    = 1'b0;
                end else if (pend_q) begin
                    if (scl_fall) begin
                        pend_d   = 1'b0;
                        sda_oe_d = 1'b1;
                        if (state_q == ST_ADDR) begin
                            state_d     = ST_ADDR_ACK;
                            addressed_d = 1'b1;
                        end else begin
                            state_d = ST_DATA_ACK;
                        end
                    end
                end else if (scl_rise) begin
                    shift_d = byte_c[SHIFT_W-1:0];
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(7)) begin
                        if (state_q == ST_ADDR) begin
                            if (addr_match) begin
                                pend_d = 1'b1;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end else begin
                            if (Accept) begin
                                data_d  = byte_c;
                                valid_d = 1'b1;
                                pend_d  = 1'b1;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
            end

            ST_ADDR_ACK, ST_DATA_ACK: begin
                // SDA edges here are our own drive, so START/STOP are not decoded.
                if (scl_fall) begin
                    state_d  = ST_DATA;
                    cnt_d    = '0;
                    sda_oe_d = 1'b0;
                end
            end

            ST_IGNORE: begin
                sda_oe_d = 1'b0;
                if (start_det) begin
                    state_d     = ST_ADDR;
                    cnt_d       = '0;
                    pend_d      = 1'b0;
                    addressed_d = 1'b0;
                end else if (stop_det) begin
                    state_d     = ST_IDLE;
                    pend_d      = 1'b0;
                    addressed_d = 1'b0;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                pend_d      = 1'b0;
                addressed_d = 1'b0;
                sda_oe_d    = 1'b0;
            end
        endcase
    end

    assign Data      = data_q;
    assign DataValid = valid_q;
    assign Addressed = addressed_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged controller on SCL/SDA with pull-up.
`timescale 1ns/1ps
module tb_i2c_target;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_r;
    logic       sda_drv_low;
    logic       accept;
    logic [7:0] data;
    logic       data_valid;
    logic       addressed;
    wire        sda_bus;

    int n_checks = 0;
    int n_errors = 0;

    int         valid_cnt = 0;
    int         valid_wide = 0;
    int         sda_drive_cnt = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] last_data = 8'h00;

    assign sda_bus = sda_drv_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_target #(.ADDRESS(7'h3C)) dut (
        .Clock    (clk),
        .Reset_n  (rst_n),
        .SCL      (scl_r),
        .SDA      (sda_bus),
        .Accept   (accept),
        .Data     (data),
        .DataValid(data_valid),
        .Addressed(addressed)
    );

    // Bus monitor: count DataValid pulses, over-long pulses and target pull-downs.
    always @(negedge clk) begin
        if (data_valid) begin
            valid_cnt = valid_cnt + 1;
            last_data = data;
            if (prev_valid) valid_wide = valid_wide + 1;
        end
        prev_valid = data_valid;
        if (sda_bus == 1'b0 && !sda_drv_low) sda_drive_cnt = sda_drive_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sda_drv_low = ~b;
        wait_clk(4);
        scl_r = 1'b1;
        wait_clk(8);
        scl_r = 1'b0;
        wait_clk(4);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic gen_start();
        sda_drv_low = 1'b0;
        wait_clk(4);
        scl_r = 1'b1;
        wait_clk(8);
        sda_drv_low = 1'b1;
        wait_clk(8);
        scl_r = 1'b0;
        wait_clk(4);
    endtask

    task automatic gen_stop();
        sda_drv_low = 1'b1;
        wait_clk(4);
        scl_r = 1'b1;
        wait_clk(8);
        sda_drv_low = 1'b0;
        wait_clk(8);
    endtask

    // Ninth clock: release SDA and sample mid-high; 0 means ACK.
    task automatic ack_clock(output logic ack);
        sda_drv_low = 1'b0;
        wait_clk(4);
        scl_r = 1'b1;
        wait_clk(4);
        ack = sda_bus;
        wait_clk(4);
        scl_r = 1'b0;
        wait_clk(4);
    endtask

    initial begin
        logic ack;
        int   v0;
        int   d0;

        rst_n       = 1'b0;
        scl_r       = 1'b1;
        sda_drv_low = 1'b0;
        accept      = 1'b1;
        wait_clk(5);
        check("rst_data",      32'(data),       32'h00);
        check("rst_valid",     32'(data_valid), 32'h0);
        check("rst_addressed", 32'(addressed),  32'h0);
        check("rst_sda",       32'(sda_bus),    32'h1);
        rst_n = 1'b1;
        wait_clk(10);

        // Basic write: 0x78 then 0xA5.
        v0 = valid_cnt;
        gen_start();
        send_byte(8'h78);
        ack_clock(ack);
        check("basic_addr_ack", 32'(ack), 32'h0);
        check("basic_addressed", 32'(addressed), 32'h1);
        send_byte(8'hA5);
        ack_clock(ack);
        check("basic_data_ack", 32'(ack), 32'h0);
        check("basic_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        check("basic_last_data", 32'(last_data), 32'hA5);
        check("basic_data", 32'(data), 32'hA5);
        check("basic_addr_before_stop", 32'(addressed), 32'h1);
        gen_stop();
        wait_clk(4);
        check("basic_addr_after_stop", 32'(addressed), 32'h0);

        // Address mismatch: target must stay off the bus.
        v0 = valid_cnt;
        d0 = sda_drive_cnt;
        gen_start();
        send_byte(8'h7A);
        ack_clock(ack);
        check("mismatch_addr_nack", 32'(ack), 32'h1);
        check("mismatch_addressed", 32'(addressed), 32'h0);
        send_byte(8'h55);
        ack_clock(ack);
        check("mismatch_data_nack", 32'(ack), 32'h1);
        gen_stop();
        wait_clk(4);
        check("mismatch_valid_cnt", 32'(valid_cnt - v0), 32'd0);
        check("mismatch_no_drive", 32'(sda_drive_cnt - d0), 32'd0);
        check("mismatch_addressed_end", 32'(addressed), 32'h0);

        // Read request is NACKed and the rest of the transfer ignored.
        v0 = valid_cnt;
        gen_start();
        send_byte(8'h79);
        ack_clock(ack);
        check("read_nack", 32'(ack), 32'h1);
        check("read_addressed", 32'(addressed), 32'h0);
        send_byte(8'h00);
        ack_clock(ack);
        check("read_ignored_nack", 32'(ack), 32'h1);
        gen_stop();
        wait_clk(4);
        check("read_valid_cnt", 32'(valid_cnt - v0), 32'd0);

        // Back-pressure: second byte refused.
        v0 = valid_cnt;
        gen_start();
        send_byte(8'h78);
        ack_clock(ack);
        check("bp_addr_ack", 32'(ack), 32'h0);
        accept = 1'b1;
        send_byte(8'h11);
        ack_clock(ack);
        check("bp_first_ack", 32'(ack), 32'h0);
        accept = 1'b0;
        send_byte(8'h22);
        ack_clock(ack);
        check("bp_second_nack", 32'(ack), 32'h1);
        gen_stop();
        wait_clk(4);
        accept = 1'b1;
        check("bp_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        check("bp_data", 32'(data), 32'h11);

        // Repeated START after a partial data byte.
        v0 = valid_cnt;
        gen_start();
        send_byte(8'h78);
        ack_clock(ack);
        check("rs_first_addr_ack", 32'(ack), 32'h0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        gen_start();
        check("rs_addressed_cleared", 32'(addressed), 32'h0);
        send_byte(8'h78);
        ack_clock(ack);
        check("rs_second_addr_ack", 32'(ack), 32'h0);
        send_byte(8'h3C);
        ack_clock(ack);
        check("rs_data_ack", 32'(ack), 32'h0);
        gen_stop();
        wait_clk(4);
        check("rs_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        check("rs_last_data", 32'(last_data), 32'h3C);

        // Reset while the target holds SDA low in the address ACK.
        gen_start();
        send_byte(8'h78);
        sda_drv_low = 1'b0;
        wait_clk(4);
        check("rst_ack_sda_low", 32'(sda_bus), 32'h0);
        check("rst_ack_addressed", 32'(addressed), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_ack_sda_released", 32'(sda_bus), 32'h1);
        check("rst_ack_data", 32'(data), 32'h00);
        check("rst_ack_addressed_clr", 32'(addressed), 32'h0);
        check("rst_ack_valid", 32'(data_valid), 32'h0);
        scl_r = 1'b1;
        wait_clk(8);
        scl_r = 1'b0;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        gen_start();
        send_byte(8'h78);
        ack_clock(ack);
        check("post_rst_addr_ack", 32'(ack), 32'h0);
        check("post_rst_addressed", 32'(addressed), 32'h1);
        gen_stop();
        wait_clk(4);
        check("post_rst_addressed_end", 32'(addressed), 32'h0);

        check("valid_single_cycle", 32'(valid_wide), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
